// File: rtl/ecg_fetch_ctrl.sv
// Sequences ECG sample playback: one ROM fetch per sample tick, result handed downstream over valid/ready.
// Latency: first tick DIV cycles after start; sample_valid rises ROM_LAT+1 cycles after that tick's edge.
// Backpressure: sample/sample_valid hold until sample_ready; a tick arriving meanwhile is dropped and flags overrun.
//
// Ports:
//   clk, switch      : clock and synchronous active-high reset
//   start, stop      : one-cycle control pulses (stop dominates start)
//   loop_en          : wrap to address 0 after LAST_ADDR instead of finishing
//   rom_addr/rom_en  : ROM read request; rom_data returns ROM_LAT cycles after rom_en
//   sample*          : registered sample with valid/ready handshake
//   tick,busy,done   : status strobes
//   overrun          : sticky flag, cleared by reset or start
module ecg_fetch_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 12,
    parameter int DIV       = 250,
    parameter int ROM_LAT   = 1,
    parameter int LAST_ADDR = 4095
) (
    input  logic              clk,
    input  logic              switch,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LAT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_READ      = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_PRESENT   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [LAT_W-1:0]   lat_cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [DATA_W-1:0]  sample_q;
    logic               sample_vld_q;
    logic               overrun_q;

    logic               busy_int;
    logic               tick_int;
    logic               handshake;
    logic               at_last;
    logic               lat_done;
    logic               restart;
    logic               abort;
    logic               load_sample;

    // ------------------------------------------------------------------
    // Status decode
    // ------------------------------------------------------------------
    assign busy_int  = (state_q != S_IDLE) && (state_q != S_DONE);
    // Tick counter only advances while busy, so gating here keeps tick
    // quiet in IDLE/DONE even though the count is frozen, not cleared.
    assign tick_int  = busy_int && (tick_cnt_q == TICK_W'(DIV - 1));
    assign handshake = sample_vld_q && sample_ready;
    assign at_last   = (addr_q == ADDR_W'(LAST_ADDR));
    // WAIT_DATA spans ROM_LAT cycles after the rom_en cycle; the last of
    // them is the one where rom_data is valid.
    assign lat_done  = (lat_cnt_q == LAT_W'(ROM_LAT - 1));
    assign abort     = busy_int && stop;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        restart     = 1'b0;
        load_sample = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // stop in the same cycle suppresses the start
                if (start && !stop) begin
                    state_d = S_WAIT_TICK;
                    addr_d  = '0;
                    restart = 1'b1;
                end
            end
            S_WAIT_TICK: begin
                if (tick_int) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (lat_done) begin
                    state_d     = S_PRESENT;
                    load_sample = 1'b1;
                end
            end
            S_PRESENT: begin
                if (handshake) begin
                    if (!at_last) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_WAIT_TICK;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = S_WAIT_TICK;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        // stop overrides whatever the busy state wanted; any read in
        // flight is simply never captured.
        if (abort) begin
            state_d     = S_IDLE;
            addr_d      = '0;
            load_sample = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (switch) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            addr_q       <= '0;
            rom_addr_q   <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;

            // Free-running sample-rate divider, phase-aligned to start.
            if (restart) begin
                tick_cnt_q <= '0;
            end else if (busy_int) begin
                if (tick_int) begin
                    tick_cnt_q <= '0;
                end else begin
                    tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                end
            end

            if (state_q == S_READ) begin
                lat_cnt_q <= '0;
            end else if (state_q == S_WAIT_DATA) begin
                lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            end

            // The ROM sees the address only when a read is launched, so it
            // keeps showing the last fetched address while the internal
            // pointer advances on the handshake.
            if (state_d == S_READ) begin
                rom_addr_q <= addr_q;
            end

            if (load_sample) begin
                sample_q <= rom_data;
            end

            // Valid is exactly "in PRESENT": it rises on capture and falls
            // only via handshake, stop or reset.
            sample_vld_q <= (state_d == S_PRESENT);

            // A tick that finds the FSM anywhere but WAIT_TICK is dropped.
            if (restart) begin
                overrun_q <= 1'b0;
            end else if (tick_int && (state_q != S_WAIT_TICK)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr     = rom_addr_q;
    assign rom_en       = (state_q == S_READ);
    assign sample       = sample_q;
    assign sample_valid = sample_vld_q;
    assign tick         = tick_int;
    assign busy         = busy_int;
    assign done         = (state_q == S_DONE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ecg_fetch_ctrl.sv
// Directed bench for ecg_fetch_ctrl with DIV=8, ROM_LAT=1, LAST_ADDR=3.
// Cycle c below means the interval just after the c-th rising edge, where
// edge 0 is the one that samples the start pulse.
// ROM model returns 0x100 + address one cycle after rom_en.
module tb_ecg_fetch_ctrl;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          switch;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] rom_addr;
    logic          rom_en;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          tick;
    logic          busy;
    logic          done;
    logic          overrun;

    int n_vec  = 0;
    int n_miss = 0;

    ecg_fetch_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DIV       (8),
        .ROM_LAT   (1),
        .LAST_ADDR (3)
    ) dut (
        .clk          (clk),
        .switch       (switch),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .rom_addr     (rom_addr),
        .rom_en       (rom_en),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .tick         (tick),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rom_en) begin
            rom_data <= 12'h100 + rom_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        switch       = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        sample_ready = 1'b1;
        step();
        chk("reset_outputs",
            {2'b00, rom_addr, rom_en, sample, sample_valid, tick, busy, done, overrun},
            32'h0);
        switch = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic on_grid(input int c, input int first, input int last);
        return (c >= first) && (c <= last) && (((c - first) % 8) == 0);
    endfunction

    // Full record playback with ready tied high; optionally loops and
    // optionally fires start pulses while busy, which must change nothing.
    task automatic run_record(input bit lp, input bit poke, input int ncyc, input string nm);
        logic [5:0] exp_flags;
        int         lim;
        do_reset();
        loop_en = lp;
        do_start();
        lim = lp ? 100000 : 0;
        for (int c = 0; c <= ncyc; c++) begin
            start = poke && (c == 3 || c == 9 || c == 12);
            exp_flags = {on_grid(c, 7, lp ? 100000 : 31),
                         on_grid(c, 8, lp ? 100000 : 32),
                         on_grid(c, 10, lp ? 100000 : 34),
                         (lp || c < 35),
                         (!lp && c >= 35),
                         1'b0};
            chk($sformatf("%s c%0d tick/en/vld/busy/done/ovr", nm, c),
                {26'd0, tick, rom_en, sample_valid, busy, done, overrun},
                {26'd0, exp_flags});
            if (exp_flags[4]) begin
                chk($sformatf("%s c%0d rom_addr", nm, c), 32'(rom_addr), 32'(((c - 8) / 8) % 4));
            end
            if (exp_flags[3]) begin
                chk($sformatf("%s c%0d sample", nm, c), 32'(sample), 32'(12'h100 + ((c - 10) / 8) % 4));
            end
            if (c == 20) begin
                chk($sformatf("%s c20 rom_addr_hold", nm), 32'(rom_addr), 32'd1);
            end
            if (!lp && c == 40) begin
                chk($sformatf("%s c40 rom_addr_done", nm), 32'(rom_addr), 32'd3);
            end
            step();
        end
        start = 1'b0;
        if (lim == 0) loop_en = 1'b0;
    endtask

    // Stall past a tick (overrun), resume, stop mid-read, restart.
    task automatic run_overrun_stop();
        logic tick_e, en_e, vld_e, busy_e;
        do_reset();
        loop_en = 1'b0;
        do_start();
        for (int c = 0; c <= 48; c++) begin
            sample_ready = !(c >= 10 && c <= 21);
            stop         = (c == 33);
            start        = (c == 36);
            tick_e = (c == 7 || c == 15 || c == 23 || c == 31 || c == 44);
            en_e   = (c == 8 || c == 24 || c == 32 || c == 45);
            vld_e  = (c >= 10 && c <= 22) || c == 26 || c == 47;
            busy_e = (c < 34) || (c >= 37);
            chk($sformatf("ovr c%0d tick/en/vld/busy/done", c),
                {27'd0, tick, rom_en, sample_valid, busy, done},
                {27'd0, tick_e, en_e, vld_e, busy_e, 1'b0});
            if (c != 15) begin
                chk($sformatf("ovr c%0d overrun", c), 32'(overrun), 32'(c >= 16 && c <= 36));
            end
            case (c)
                22: chk("ovr c22 sample_held", 32'(sample), 32'h100);
                24: chk("ovr c24 rom_addr",    32'(rom_addr), 32'd1);
                26: chk("ovr c26 sample",      32'(sample), 32'h101);
                32: chk("ovr c32 rom_addr",    32'(rom_addr), 32'd2);
                45: chk("ovr c45 rom_addr",    32'(rom_addr), 32'd0);
                47: chk("ovr c47 sample",      32'(sample), 32'h100);
                default: ;
            endcase
            step();
        end
        stop  = 1'b0;
        start = 1'b0;
    endtask

    // Reset while presenting a stalled sample, then start+stop while idle.
    task automatic run_reset_present();
        do_reset();
        loop_en = 1'b0;
        do_start();
        for (int c = 0; c <= 16; c++) begin
            sample_ready = (c < 10);
            if (c == 12) begin
                chk("rst c12 sample_valid", 32'(sample_valid), 32'd1);
                chk("rst c12 sample",       32'(sample),       32'h100);
            end
            if (c == 16) begin
                chk("rst c16 overrun", 32'(overrun), 32'd1);
            end
            step();
        end
        switch = 1'b1;
        step();
        chk("rst c18 all_outputs",
            {2'b00, rom_addr, rom_en, sample, sample_valid, tick, busy, done, overrun},
            32'h0);
        switch       = 1'b0;
        sample_ready = 1'b1;
        start        = 1'b1;
        stop         = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("startstop +%0d tick/en/busy", c),
                {29'd0, tick, rom_en, busy}, 32'd0);
            step();
        end
    endtask

    initial begin
        switch       = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        loop_en      = 1'b0;
        sample_ready = 1'b1;

        run_record(1'b0, 1'b0, 44, "stop_mode");
        run_record(1'b1, 1'b0, 44, "loop_mode");
        run_overrun_stop();
        run_reset_present();
        run_record(1'b0, 1'b1, 44, "start_busy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
